// File: rtl/seq_circ_pkg.sv
// -----------------------------------------------------------------------------
// seq_circ_pkg
// Shared definitions for the seq_circ multi-cycle arithmetic unit:
//   DATA_W  - datapath width (8 bits)
//   data_t  - one datapath word
//   state_t - controller state encoding
// -----------------------------------------------------------------------------
package seq_circ_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADD_AB  = 3'd1,
    ADD_CD  = 3'd2,
    COMBINE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage : seq_circ_pkg

// File: rtl/seq_circ_alu.sv
// -----------------------------------------------------------------------------
// seq_circ_alu
// Combinational 8-bit adder/subtractor shared by every compute state of
// seq_circ. Wraps modulo 2**DATA_W.
//
// Ports:
//   a, b  in   DATA_W  operands
//   sub   in   1       0 = a + b, 1 = a - b
//   y     out  DATA_W  wrapped result
//   co    out  1       carry-out (add) or borrow (sub); only present when
//                      SEQ_CIRC_OVF_EN is defined
// -----------------------------------------------------------------------------
module seq_circ_alu
  import seq_circ_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] y
`ifdef SEQ_CIRC_OVF_EN
  ,
  output logic              co
`endif
);

`ifdef SEQ_CIRC_OVF_EN
  // One extra bit catches the carry; for subtraction the same bit is set
  // exactly when a < b, i.e. it is the borrow.
  logic [DATA_W:0] wide;

  always_comb begin
    if (sub) wide = {1'b0, a} - {1'b0, b};
    else     wide = {1'b0, a} + {1'b0, b};
  end

  assign y  = wide[DATA_W-1:0];
  assign co = wide[DATA_W];
`else
  assign y = sub ? (a - b) : (a + b);
`endif

endmodule : seq_circ_alu

// File: rtl/seq_circ.sv
// -----------------------------------------------------------------------------
// seq_circ
// Multi-cycle unit computing (A+B)+(C+D) or (A+B)-(C+D) through a single
// shared adder/subtractor. A level-sensitive start is accepted in IDLE; the
// registered result appears with done four rising edges later (counting the
// accepting edge). done stays high in DONE until start is seen low.
//
// Ports:
//   reset       in   1       synchronous, active-high
//   clk         in   1       rising-edge clock
//   start       in   1       request, sampled in IDLE and DONE
//   mode        in   1       0 = sum of pairs, 1 = difference of pairs
//   A, B, C, D  in   8 each  unsigned operands, captured on acceptance
//   result      out  8       registered result
//   done        out  1       registered, high while result is valid
//   ovf         out  1       any carry/borrow during the operation; only
//                            present when SEQ_CIRC_OVF_EN is defined
//
// Build option: define SEQ_CIRC_OVF_EN to add the ovf port and carry tracking.
// -----------------------------------------------------------------------------
module seq_circ
  import seq_circ_pkg::*;
(
  input  logic              reset,
  input  logic              clk,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] result,
  output logic              done
`ifdef SEQ_CIRC_OVF_EN
  ,
  output logic              ovf
`endif
);

  state_t state, state_nxt;

  data_t a_q, b_q, c_q, d_q;
  logic  mode_q;
  data_t r1, r2;

  data_t alu_a, alu_b, alu_y;
  logic  alu_sub;

`ifdef SEQ_CIRC_OVF_EN
  logic alu_co;
  logic ovf_q;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ADD_AB;
      ADD_AB:  state_nxt = ADD_CD;
      ADD_CD:  state_nxt = COMBINE;
      COMBINE: state_nxt = DONE;
      // Holding start keeps us here so one request yields one computation.
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared ALU operand selection
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_a   = r1;
    alu_b   = r2;
    alu_sub = 1'b0;
    case (state)
      ADD_AB: begin
        alu_a = a_q;
        alu_b = b_q;
      end
      ADD_CD: begin
        alu_a = c_q;
        alu_b = d_q;
      end
      COMBINE: begin
        alu_sub = mode_q;
      end
      default: ;
    endcase
  end

  seq_circ_alu u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sub (alu_sub),
    .y   (alu_y)
`ifdef SEQ_CIRC_OVF_EN
    ,
    .co  (alu_co)
`endif
  );

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      mode_q <= 1'b0;
      r1     <= '0;
      r2     <= '0;
      result <= '0;
      done   <= 1'b0;
`ifdef SEQ_CIRC_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            c_q    <= C;
            d_q    <= D;
            mode_q <= mode;
`ifdef SEQ_CIRC_OVF_EN
            ovf_q  <= 1'b0;
`endif
          end
        end
        ADD_AB: begin
          r1 <= alu_y;
`ifdef SEQ_CIRC_OVF_EN
          ovf_q <= ovf_q | alu_co;
`endif
        end
        ADD_CD: begin
          r2 <= alu_y;
`ifdef SEQ_CIRC_OVF_EN
          ovf_q <= ovf_q | alu_co;
`endif
        end
        COMBINE: begin
          result <= alu_y;
          done   <= 1'b1;
`ifdef SEQ_CIRC_OVF_EN
          ovf_q  <= ovf_q | alu_co;
`endif
        end
        DONE: begin
          if (!start) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_CIRC_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule : seq_circ

// File: tb/tb_seq_circ.sv
// -----------------------------------------------------------------------------
// tb_seq_circ
// Self-checking bench for seq_circ: directed cases, reset abort, long start
// hold, then randomized operations against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_circ;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] a, b, c, d;
  logic [7:0] result;
  logic       done;
`ifdef SEQ_CIRC_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] last_res;

  seq_circ dut (
    .reset  (reset),
    .clk    (clk),
    .start  (start),
    .mode   (mode),
    .A      (a),
    .B      (b),
    .C      (c),
    .D      (d),
    .result (result),
    .done   (done)
`ifdef SEQ_CIRC_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ((A+B) op (C+D)) reduced mod 256.
  function automatic logic [7:0] model_res(input logic [7:0] ia, ib, ic, id, input logic im);
    int s1 = int'(ia) + int'(ib);
    int s2 = int'(ic) + int'(id);
    int r  = im ? (s1 - s2) : (s1 + s2);
    return 8'(r);
  endfunction

  function automatic logic model_ovf(input logic [7:0] ia, ib, ic, id, input logic im);
    int s1 = int'(ia) + int'(ib);
    int s2 = int'(ic) + int'(id);
    int w1 = s1 % 256;
    int w2 = s2 % 256;
    logic last = im ? (w1 < w2) : (w1 + w2 > 255);
    return (s1 > 255) || (s2 > 255) || last;
  endfunction

  task automatic scramble();
    a    = 8'($urandom);
    b    = 8'($urandom);
    c    = 8'($urandom);
    d    = 8'($urandom);
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_result", result, 8'h00);
    check("rst_done", {7'd0, done}, 8'd0);
    last_res = 8'h00;
  endtask

  // Issue one request and check timing and result; start is left high.
  task automatic run_op(input logic [7:0] ia, ib, ic, id, input logic im, input string tag);
    logic [7:0] exp;
    a = ia; b = ib; c = ic; d = id; mode = im;
    exp = model_res(ia, ib, ic, id, im);
    start = 1'b1;
    tick();
    check({tag, "_busy0"}, {7'd0, done}, 8'd0);
    scramble();
    tick();
    check({tag, "_busy1"}, {7'd0, done}, 8'd0);
    scramble();
    tick();
    check({tag, "_busy2"}, {7'd0, done}, 8'd0);
    scramble();
    tick();
    check({tag, "_done"}, {7'd0, done}, 8'd1);
    check({tag, "_res"}, result, exp);
`ifdef SEQ_CIRC_OVF_EN
    check({tag, "_ovf"}, {7'd0, ovf}, {7'd0, model_ovf(ia, ib, ic, id, im)});
`endif
    last_res = exp;
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_drop_done"}, {7'd0, done}, 8'd0);
    check({tag, "_drop_hold"}, result, last_res);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    last_res = '0;

    // Directed cases from the wrap/borrow corners.
    do_reset();
    run_op(8'h01, 8'h02, 8'hFF, 8'hFE, 1'b0, "d1");
    drop_start("d1");

    do_reset();
    run_op(8'hFE, 8'h01, 8'h01, 8'h04, 1'b1, "d2");
    drop_start("d2");

    do_reset();
    run_op(8'h01, 8'hFF, 8'hFF, 8'hFF, 1'b0, "d3");
    drop_start("d3");

    do_reset();
    run_op(8'hFF, 8'h01, 8'hFF, 8'h01, 1'b1, "d4");
    drop_start("d4");

    // Reset two edges into a computation aborts it without a done pulse.
    run_op(8'h10, 8'h20, 8'h30, 8'h40, 1'b0, "pre");
    drop_start("pre");
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44; mode = 1'b0;
    start = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    last_res = 8'h00;
    check("abort_result", result, 8'h00);
    check("abort_done", {7'd0, done}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_nopulse", {7'd0, done}, 8'd0);
    end
    run_op(8'h05, 8'h06, 8'h07, 8'h08, 1'b1, "fresh");

    // start held high after done: exactly one computation.
    for (int i = 0; i < 10; i++) begin
      scramble();
      tick();
      check("hold_done", {7'd0, done}, 8'd1);
      check("hold_res", result, last_res);
    end
    drop_start("hold");
    run_op(8'h80, 8'h7F, 8'h03, 8'h02, 1'b1, "after_hold");
    drop_start("after_hold");

    // Randomized operations with random idle gaps and start-hold lengths.
    for (int n = 0; n < 40; n++) begin
      int gap  = $urandom_range(0, 3);
      int hold = $urandom_range(0, 3);
      start = 1'b0;
      for (int g = 0; g < gap; g++) begin
        scramble();
        tick();
        check("rnd_idle_done", {7'd0, done}, 8'd0);
        check("rnd_idle_res", result, last_res);
      end
      run_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), "rnd");
      for (int h = 0; h < hold; h++) begin
        scramble();
        tick();
        check("rnd_hold_done", {7'd0, done}, 8'd1);
        check("rnd_hold_res", result, last_res);
      end
      drop_start("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_circ
